// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the UART stream bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } tx_state_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_stream_bridge_if.sv
// Bridge-side bundle: UART core pins, processor stream ports, status and statistics.
interface uart_stream_bridge_if
  import uart_bridge_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int CNT_W    = 16
);
  localparam int RX_LW = lvl_w(RX_DEPTH);
  localparam int TX_LW = lvl_w(TX_DEPTH);

  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_enable;
  logic              tx_done;
  logic              rx_overflow;
  logic              clr_ovf;
  logic [RX_LW-1:0]  rx_level;
  logic [TX_LW-1:0]  tx_level;
  logic [CNT_W-1:0]  rx_count;
  logic [CNT_W-1:0]  tx_count;

  modport slave (
    input  rx_data, rx_done, m_ready, s_data, s_valid, tx_done, clr_ovf,
    output m_data, m_valid, s_ready, tx_data, tx_enable, rx_overflow,
           rx_level, tx_level, rx_count, tx_count
  );

  modport master (
    output rx_data, rx_done, m_ready, s_data, s_valid, tx_done, clr_ovf,
    input  m_data, m_valid, s_ready, tx_data, tx_enable, rx_overflow,
           rx_level, tx_level, rx_count, tx_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module sync_fifo
  import uart_bridge_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int LW     = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              wr;
  logic              rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign head  = mem[rptr[AW-1:0]];
  assign level = wptr - rptr;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Buffers UART RX words into a valid/ready stream and drains a TX FIFO into the TX core.
// Optional statistics counters enabled by UART_BRIDGE_STATS_EN.
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  uart_stream_bridge_if.slave bus
);
  localparam int RX_LW = lvl_w(RX_DEPTH);
  localparam int TX_LW = lvl_w(TX_DEPTH);

  logic [DATA_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_pop;
  logic [RX_LW-1:0]  rx_level;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_pop;
  logic [TX_LW-1:0]  tx_level;

  tx_state_t         state;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_en_q;
  logic              ovf_q;

  assign rx_pop = ~rx_empty & bus.m_ready;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.rx_done),
    .push_data (bus.rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.s_valid & ~tx_full),
    .push_data (bus.s_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  // FIFO storage is not reset, so the head is masked to keep m_data at zero when empty
  assign bus.m_data   = rx_empty ? '0 : rx_head;
  assign bus.m_valid  = ~rx_empty;
  assign bus.s_ready  = ~tx_full;
  assign bus.rx_level = rx_level;
  assign bus.tx_level = tx_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.rx_done & rx_full & ~rx_pop) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.rx_overflow = ovf_q;

  assign tx_pop = (state == IDLE) & ~tx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty) begin
            tx_data_q <= tx_head;
            tx_en_q   <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          tx_en_q <= 1'b0;
          state   <= BUSY;
        end
        BUSY: begin
          if (bus.tx_done) state <= IDLE;
        end
        default: begin
          tx_en_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_enable = tx_en_q;

`ifdef UART_BRIDGE_STATS_EN
  logic [CNT_W-1:0] rx_cnt_q;
  logic [CNT_W-1:0] tx_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (bus.rx_done & (~rx_full | rx_pop)) rx_cnt_q <= rx_cnt_q + 1'b1;
      if ((state == BUSY) & bus.tx_done)     tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  assign bus.rx_count = rx_cnt_q;
  assign bus.tx_count = tx_cnt_q;
`else
  assign bus.rx_count = '0;
  assign bus.tx_count = '0;
`endif

endmodule
